mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1-muxed resource (e.g. a memory or bus port) between four requesters.
- Produces the registered 2-bit select that drives the 4:1 mux, plus a one-hot grant back to the requesters.
- A grant is held for a burst until the owner drops its request, the resource signals done, or a burst limit expires.

Parameters:
- MAX_BURST, 8: maximum cycles one owner may hold the grant; 0 = unlimited.
- CNT_W, 4: width of the burst counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i wants the resource.
- done  input  1  resource signals the current transfer is complete; ignored when no grant is active.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  registered mux select; index of the current or most recent owner.
- busy  output  1  high while a grant is active (gnt != 0).

Behaviour:
- States: IDLE and GRANT.
  - Internal registers: 2-bit last pointer and CNT_W-bit burst_cnt.
- Reset: registers load the following on the first rising clk edge with rst=1.
  - state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, last=2'b11, burst_cnt=0.
  - Because last=3 after reset, requester 0 has top priority first.
- rst overrides everything, including mid-burst: the grant drops on that edge and no done or req is honoured.
- Priority scan: start at (last+1) mod 4 and proceed upward with wrap-around (3 wraps to 0). The first set req bit wins.
- IDLE:
  - If req==0, stay in IDLE; outputs unchanged, gnt=0.
  - Otherwise, on the next edge: gnt=onehot(winner), sel=winner, busy=1, burst_cnt=1, state=GRANT.
  - Latency: req asserted in cycle N gives gnt visible in cycle N+1.
- GRANT: the owner is sel. Release is evaluated every cycle and is true if any of these hold:
  - req[sel]==0,
  - done==1,
  - MAX_BURST!=0 and burst_cnt==MAX_BURST.
- No release: hold gnt/sel; burst_cnt increments and saturates at its maximum value.
- On release, set last=sel, then evaluate the other requesters (req with bit sel masked off):
  - If any are pending, hand over on the same edge with no bubble: scan from sel+1, gnt/sel = new winner, burst_cnt=1, stay in GRANT.
  - If none are pending: gnt=0, busy=0, state=IDLE. sel keeps its value.
  - The releasing owner therefore cannot win back-to-back. If it is still requesting, it is re-granted from IDLE after exactly one idle cycle.
- Simultaneous done and burst expiry count as a single release; there is no double advance.
- done asserted in IDLE has no effect.
- gnt is always one-hot or zero, and gnt[sel]==1 whenever busy==1.
- With MAX_BURST=0, the counter is not checked, and an owner holding req with no done keeps the grant indefinitely.

Test Plan:
- Reset/first grant: assert rst for 2 cycles with req=4'b1111, then release -> gnt=0000, sel=00 during reset; one cycle after rst falls, gnt=0001, sel=00, busy=1.
- Round-robin rotation: req=4'b1111 held, done pulsed once per grant -> owners 0,1,2,3,0 in consecutive grants, each handover with no idle cycle.
- Burst limit (MAX_BURST=8): only req[2] held, no done -> gnt=0100 for exactly 8 cycles, then 1 cycle gnt=0000, then gnt=0100 again.
- Owner drop with pending peer: owner 1 granted, req=4'b1001, then req[1] falls -> next edge gnt=1000, sel=11 (scan from 2 finds 3 before 0).
- done in IDLE and mid-burst reset: pulse done with req=0 -> no change, busy=0; during grant to 3, assert rst -> next edge gnt=0, sel=00, last=3, and the next grant goes to requester 0.
- Wrap-around: last=3, req=4'b1000 only -> grant 3; release; req=4'b1001 -> grant 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1-muxed resource. Grants are held as a
// burst until the owner drops req, the resource reports done, or the limit hits.
module mux4_rr_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       gnt_reg, gnt_next;
    logic [1:0]       sel_reg, sel_next;
    logic [1:0]       last_reg, last_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             burst_hit;
    logic             release_now;
    logic [3:0]       cand;
    logic [1:0]       scan_start;
    logic [3:0]       rot;
    logic [1:0]       offset;
    logic [1:0]       winner;
    logic [3:0]       winner_onehot;

    generate
        if (MAX_BURST != 0) begin : g_limit
            assign burst_hit = (cnt_reg == CNT_W'(MAX_BURST));
        end else begin : g_unlimited
            assign burst_hit = 1'b0;
        end
    endgenerate

    assign release_now = (state_reg == GRANT) && (!req[sel_reg] || done || burst_hit);

    // On release the owner is masked off and the scan starts just past it;
    // from IDLE the scan starts just past the most recent owner.
    assign cand       = release_now ? (req & ~gnt_reg) : req;
    assign scan_start = release_now ? (sel_reg + 2'd1) : (last_reg + 2'd1);

    // Rotate candidates so that bit 0 is the highest-priority requester.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] idx;
            assign idx     = scan_start + 2'(gi);
            assign rot[gi] = cand[idx];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) begin
                offset = 2'(i);
            end
        end
    end

    assign winner        = scan_start + offset;
    assign winner_onehot = 4'b0001 << winner;

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_next = GRANT;
                    gnt_next   = winner_onehot;
                    sel_next   = winner;
                    cnt_next   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_next = sel_reg;
                    if (cand != 4'b0000) begin
                        gnt_next = winner_onehot;
                        sel_next = winner;
                        cnt_next = CNT_W'(1);
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 4'b0000;
                    end
                end else if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
            sel_reg   <= 2'b00;
            last_reg  <= 2'b11;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign gnt  = gnt_reg;
    assign sel  = sel_reg;
    assign busy = (state_reg == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations, then
// random traffic compared each cycle against an integer-level arbitration model.
module tb_mux4_rr_arbiter;

    localparam int MAX_BURST = 8;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Model state: owner is -1 when nobody holds the resource.
    int m_owner = -1;
    int m_sel   = 0;
    int m_last  = 3;
    int m_cnt   = 0;

    mux4_rr_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .done(done),
        .gnt (gnt),
        .sel (sel),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int scan(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic r, input logic [3:0] q, input logic d);
        int w;
        bit rel;
        logic [3:0] others;
        if (r) begin
            m_owner = -1; m_sel = 0; m_last = 3; m_cnt = 0;
        end else if (m_owner < 0) begin
            w = scan(q, m_last + 1);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_cnt = 1;
            end
        end else begin
            rel = !q[m_owner] || d || (MAX_BURST != 0 && m_cnt == MAX_BURST);
            if (rel) begin
                m_last = m_owner;
                others = q & ~(4'b0001 << m_owner);
                w = scan(others, m_owner + 1);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_cnt = 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end
        end
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got gnt=%b sel=%0d busy=%b, want gnt=%b sel=%0d busy=%b",
                     name, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    // Drive one cycle, advance the model, and compare #1 after the edge.
    task automatic cycle(input logic r, input logic [3:0] q, input logic d, input string name);
        logic [3:0] eg;
        rst = r; req = q; done = d;
        @(posedge clk);
        model_step(r, q, d);
        #1;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check(name, {gnt, sel, busy}, {eg, 2'(m_sel), (m_owner >= 0)});
        $display("cyc rst=%b req=%b done=%b -> gnt=%b sel=%0d busy=%b", r, q, d, gnt, sel, busy);
    endtask

    task automatic lit(input string name, input logic [3:0] eg, input logic [1:0] es, input logic eb);
        check(name, {gnt, sel, busy}, {eg, es, eb});
    endtask

    initial begin
        // Reset held two cycles with all requesting, then first grant to 0.
        cycle(1, 4'b1111, 0, "reset0");
        lit("reset0_lit", 4'b0000, 2'd0, 1'b0);
        cycle(1, 4'b1111, 0, "reset1");
        lit("reset1_lit", 4'b0000, 2'd0, 1'b0);
        cycle(0, 4'b1111, 0, "first");
        lit("first_lit", 4'b0001, 2'd0, 1'b1);

        // Rotation with done pulses: no idle cycle between owners.
        cycle(0, 4'b1111, 1, "rot1"); lit("rot1_lit", 4'b0010, 2'd1, 1'b1);
        cycle(0, 4'b1111, 1, "rot2"); lit("rot2_lit", 4'b0100, 2'd2, 1'b1);
        cycle(0, 4'b1111, 1, "rot3"); lit("rot3_lit", 4'b1000, 2'd3, 1'b1);
        cycle(0, 4'b1111, 1, "rot0"); lit("rot0_lit", 4'b0001, 2'd0, 1'b1);

        // Burst limit: 8 cycles of grant to 2, one idle, then re-grant.
        cycle(1, 4'b0000, 0, "rst_b");
        for (int i = 0; i < 10; i++) begin
            cycle(0, 4'b0100, 0, "burst");
            lit("burst_lit", (i == 8) ? 4'b0000 : 4'b0100, 2'd2, (i != 8));
        end

        // Owner 1 drops with 0 and 3 pending: scan from 2 picks 3.
        cycle(1, 4'b0000, 0, "rst_d");
        cycle(0, 4'b0010, 0, "own1"); lit("own1_lit", 4'b0010, 2'd1, 1'b1);
        cycle(0, 4'b1001, 0, "drop"); lit("drop_lit", 4'b1000, 2'd3, 1'b1);

        // done in IDLE is ignored; reset mid-burst; next grant goes to 0.
        cycle(1, 4'b0000, 0, "rst_i");
        cycle(0, 4'b0000, 1, "idle_done"); lit("idle_done_lit", 4'b0000, 2'd0, 1'b0);
        cycle(0, 4'b1000, 0, "g3");         lit("g3_lit", 4'b1000, 2'd3, 1'b1);
        cycle(1, 4'b1000, 1, "mid_rst");    lit("mid_rst_lit", 4'b0000, 2'd0, 1'b0);
        cycle(0, 4'b1111, 0, "after_rst");  lit("after_rst_lit", 4'b0001, 2'd0, 1'b1);

        // Wrap-around: after owner 3 releases, scan from 0.
        cycle(1, 4'b0000, 0, "rst_w");
        cycle(0, 4'b1000, 0, "w3");   lit("w3_lit", 4'b1000, 2'd3, 1'b1);
        cycle(0, 4'b0000, 0, "wrel"); lit("wrel_lit", 4'b0000, 2'd3, 1'b0);
        cycle(0, 4'b1001, 0, "w0");   lit("w0_lit", 4'b0001, 2'd0, 1'b1);

        // Random traffic with sticky requests so bursts develop.
        begin
            logic [3:0] q;
            q = 4'b0000;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
                cycle(($urandom_range(0, 99) == 0), q, ($urandom_range(0, 5) == 0), "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
